// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between the instruction decoder and the ALU.
// Owns an 8x16 register file, issues one op at a time and writes results and NZVC back.
module alu_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int ALU_LAT = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [4:0]       in_shift,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [1:0]       dbg_state,
  output logic [3:0]       alu_optcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  output logic [3:0]       flags_nzvc,
  output logic             done,
  output logic             err
);

  // Handshake: an instruction is accepted on a rising edge where in_valid and
  // in_ready are both high; in_valid may stay high across back-to-back ops and
  // the instruction fields must be stable while in_valid is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_LAST = 4'd9;
  localparam int         CW      = 3;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    rd_q;
  logic             issue, illegal, wb;
  logic [WIDTH-1:0] regs [NREGS];

  assign in_ready  = (state_q == IDLE);
  assign dbg_state = state_q;
  assign dbg_data  = regs[dbg_addr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    illegal = 1'b0;
    wb      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_op <= OP_LAST) begin
            issue   = 1'b1;
            cnt_d   = CW'(ALU_LAT);
            state_d = EXEC;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      EXEC: begin
        // The ALU result is valid once the counter has run down to zero.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = WB;
      end
      WB: begin
        wb      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      alu_optcode <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shift   <= '0;
      flags_nzvc  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= wb;
      err     <= illegal;
      if (issue) begin
        alu_optcode <= in_op;
        alu_a       <= regs[in_rs];
        alu_b       <= regs[in_rt];
        alu_shift   <= in_shift;
        rd_q        <= in_rd;
      end
      if (wb) flags_nzvc <= {alu_n, alu_z, alu_v, alu_c};
    end
  end

  // Writeback is placed after the load so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (wb && (alu_optcode != OP_CMP)) regs[rd_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural one-cycle ALU attached.
module tb_alu_issue_ctrl;

  localparam int ALU_LAT = 1;
  localparam int EXP_LAT = ALU_LAT + 1;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, OR_ = 4'd3, AND_ = 4'd4;
  localparam logic [3:0] XOR_ = 4'd5, SHR = 4'd6, SHL = 4'd7, ROR = 4'd8, CMP = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic [4:0]  in_shift;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [1:0]  dbg_state;
  logic [3:0]  alu_optcode;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_result;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic [3:0]  flags_nzvc;
  logic        done, err;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_ctrl #(.WIDTH(16), .NREGS(8), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shift(in_shift),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state),
    .alu_optcode(alu_optcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .flags_nzvc(flags_nzvc), .done(done), .err(err)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: returns {N,Z,V,C,result}; C is carry for ADD, borrow for SUB/CMP.
  function automatic logic [19:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [4:0] sh);
    logic [16:0] w;
    logic [31:0] t;
    logic [15:0] r;
    logic        v, c;
    r = '0; v = 1'b0; c = 1'b0; w = '0; t = '0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1, 4'd9: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: begin t = 32'(a) * 32'(b); r = t[15:0]; end
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = a << sh;
      4'd8: begin t = {a, a} >> sh[3:0]; r = t[15:0]; end
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0), v, c, r};
  endfunction

  always @(posedge clk) begin
    {alu_n, alu_z, alu_v, alu_c, alu_result} <= alu_eval(alu_optcode, alu_a, alu_b, alu_shift);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] addr, output logic [15:0] data);
    dbg_addr = addr;
    #1;
    data = dbg_data;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [4:0] sh);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_shift = sh;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [4:0]  sh;
    logic [15:0] init_rd, a, b, exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] rv;
    logic [3:0]  prev_f;
    int          lat;
    int          seen;

    vecs[0]  = '{ADD,  3'd3, 3'd1, 3'd2, 5'd0,  16'h1234, 16'h0005, 16'h0001, 16'h0006, 4'b0000};
    vecs[1]  = '{ADD,  3'd4, 3'd1, 3'd2, 5'd0,  16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
    vecs[2]  = '{CMP,  3'd5, 3'd1, 3'd2, 5'd0,  16'hBEEF, 16'd11,   16'd11,   16'hBEEF, 4'b0100};
    vecs[3]  = '{CMP,  3'd5, 3'd1, 3'd2, 5'd0,  16'hBEEF, 16'd10,   16'd11,   16'hBEEF, 4'b1001};
    vecs[4]  = '{SUB,  3'd0, 3'd1, 3'd2, 5'd0,  16'h5555, 16'h0003, 16'h0005, 16'hFFFE, 4'b1001};
    vecs[5]  = '{MUL,  3'd6, 3'd3, 3'd4, 5'd0,  16'h0000, 16'h0012, 16'h0034, 16'h03A8, 4'b0000};
    vecs[6]  = '{OR_,  3'd7, 3'd1, 3'd2, 5'd0,  16'h0000, 16'hF0F0, 16'h0F00, 16'hFFF0, 4'b1000};
    vecs[7]  = '{AND_, 3'd7, 3'd1, 3'd2, 5'd0,  16'h0001, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b0100};
    vecs[8]  = '{SHR,  3'd2, 3'd1, 3'd3, 5'd4,  16'h0000, 16'h8000, 16'h0000, 16'h0800, 4'b0000};
    vecs[9]  = '{SHL,  3'd2, 3'd1, 3'd3, 5'd15, 16'h0000, 16'h0003, 16'h0000, 16'h8000, 4'b1000};
    vecs[10] = '{ROR,  3'd1, 3'd2, 3'd3, 5'd1,  16'h0000, 16'h0001, 16'h0000, 16'h8000, 4'b1000};
    vecs[11] = '{XOR_, 3'd6, 3'd4, 3'd5, 5'd0,  16'h0000, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_shift = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    tick(); tick();
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_flags", flags_nzvc, 0);
    check("rst_optcode", alu_optcode, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);
    read_reg(3'd7, rv);
    check("rst_r7", rv, 0);

    // Table-driven vectors
    prev_f = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      load(vecs[i].rd, vecs[i].init_rd);
      load(vecs[i].rs, vecs[i].a);
      if (vecs[i].rt != vecs[i].rs) load(vecs[i].rt, vecs[i].b);
      check($sformatf("v%0d_flags_kept", i), flags_nzvc, prev_f);
      check($sformatf("v%0d_ready", i), in_ready, 1);
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].sh);
      check($sformatf("v%0d_busy", i), in_ready, 0);
      check($sformatf("v%0d_state", i), dbg_state, 1);
      check($sformatf("v%0d_op", i), alu_optcode, vecs[i].op);
      check($sformatf("v%0d_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d_b", i), alu_b, vecs[i].b);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, EXP_LAT);
      check($sformatf("v%0d_ready_on_done", i), in_ready, 1);
      read_reg(vecs[i].rd, rv);
      check($sformatf("v%0d_result", i), rv, vecs[i].exp_r);
      check($sformatf("v%0d_flags", i), flags_nzvc, vecs[i].exp_f);
      tick();
      check($sformatf("v%0d_done_pulse", i), done, 0);
      prev_f = vecs[i].exp_f;
    end

    // Illegal opcode: err pulse, no issue, flags kept, next op accepted at once
    issue(4'b1100, 3'd3, 3'd1, 3'd2, 5'd0);
    in_valid = 1'b1; in_op = ADD; in_rd = 3'd3; in_rs = 3'd4; in_rt = 3'd5;
    check("ill_err", err, 1);
    check("ill_ready", in_ready, 1);
    check("ill_optcode", alu_optcode, XOR_);
    check("ill_flags", flags_nzvc, 4'b0100);
    tick();
    in_valid = 1'b0;
    check("ill_err_clear", err, 0);
    check("ill_next_accept", in_ready, 0);
    wait_done(lat);
    check("ill_next_latency", lat, EXP_LAT);
    read_reg(3'd3, rv);
    check("ill_next_result", rv, 16'h5554);

    // Back-to-back with in_valid held; r1 reloaded during the first EXEC
    load(3'd1, 16'd8);
    load(3'd2, 16'd2);
    in_valid = 1'b1; in_op = SHL; in_rd = 3'd6; in_rs = 3'd1; in_rt = 3'd2; in_shift = 5'd2;
    tick();
    check("b2b_busy1", in_ready, 0);
    in_op = XOR_; in_rd = 3'd7; in_shift = 5'd0;
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'd99;
    tick();
    ld_data = 16'd8;
    tick();
    ld_en = 1'b0;
    check("b2b_done1", done, 1);
    check("b2b_ready_on_done", in_ready, 1);
    read_reg(3'd6, rv);
    check("b2b_r6", rv, 16'd32);
    tick();
    in_valid = 1'b0;
    check("b2b_accept2", in_ready, 0);
    check("b2b_done_low", done, 0);
    check("b2b_op2", alu_optcode, XOR_);
    check("b2b_a2", alu_a, 16'd8);
    wait_done(lat);
    check("b2b_latency2", lat, EXP_LAT);
    read_reg(3'd7, rv);
    check("b2b_r7", rv, 16'd10);

    // Writeback and load hit the same register on the same edge
    load(3'd1, 16'd5);
    load(3'd2, 16'd1);
    issue(ADD, 3'd3, 3'd1, 3'd2, 5'd0);
    tick();
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hFFFF;
    tick();
    ld_en = 1'b0;
    check("coll_done", done, 1);
    read_reg(3'd3, rv);
    check("coll_wb_wins", rv, 16'd6);
    check("coll_flags", flags_nzvc, 4'b0000);

    // Reset during EXEC aborts the op
    issue(ADD, 3'd3, 3'd1, 3'd2, 5'd0);
    check("abort_state", dbg_state, 1);
    rst_n = 1'b0;
    #2;
    check("abort_ready", in_ready, 1);
    check("abort_flags", flags_nzvc, 0);
    read_reg(3'd3, rv);
    check("abort_r3", rv, 0);
    seen = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (done) seen++;
      tick();
    end
    check("abort_no_done", seen, 0);
    check("abort_ready_after", in_ready, 1);
    read_reg(3'd3, rv);
    check("abort_r3_after", rv, 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
